int_rdy_ctrl: RTL and testbench

INT_RDY_CTRL -- requirements
Module: int_rdy_ctrl

---
 rtl/int_rdy_ctrl_if.sv | 53 +++++
 rtl/int_rdy_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_int_rdy_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_rdy_ctrl_if.sv
// Interface bundle for int_rdy_ctrl.
// Carries the external asynchronous requests, the core-side handshake and
// step controls, and the registered results presented to the core.
//   ext_irq_n_i  : external IRQ, active-low level, asynchronous
//   ext_nmi_n_i  : external NMI, active-low, falling-edge sensitive, asynchronous
//   ext_rdy_i    : external ready, active-high, asynchronous
//   nmi_ack_i    : one-cycle pulse from the core, NMI vector fetch started
//   step_en_i    : single-step mode enable (synchronous)
//   step_i       : single-step request, rising edge requests one step
//   irq_o        : filtered IRQ level to the core
//   nmi_o        : pending NMI to the core
//   rdy_o        : ready to the core
//   nmi_cnt_o    : saturating count of NMIs taken
// slave  : the controller side (int_rdy_ctrl)
// master : the side that drives requests and observes the results
interface int_rdy_ctrl_if;
  logic       ext_irq_n_i;
  logic       ext_nmi_n_i;
  logic       ext_rdy_i;
  logic       nmi_ack_i;
  logic       step_en_i;
  logic       step_i;
  logic       irq_o;
  logic       nmi_o;
  logic       rdy_o;
  logic [7:0] nmi_cnt_o;

  modport slave (
    input  ext_irq_n_i,
    input  ext_nmi_n_i,
    input  ext_rdy_i,
    input  nmi_ack_i,
    input  step_en_i,
    input  step_i,
    output irq_o,
    output nmi_o,
    output rdy_o,
    output nmi_cnt_o
  );

  modport master (
    output ext_irq_n_i,
    output ext_nmi_n_i,
    output ext_rdy_i,
    output nmi_ack_i,
    output step_en_i,
    output step_i,
    input  irq_o,
    input  nmi_o,
    input  rdy_o,
    input  nmi_cnt_o
  );
endinterface

// File: rtl/int_rdy_ctrl.sv
// Interrupt and ready controller for a CPU core.
// Synchronises the external IRQ, NMI and RDY lines, filters IRQ, turns NMI
// falling edges into a pending/served handshake with the core, counts NMIs
// taken, and gates ready for single-step operation.
// Ports:
//   clk_i : system clock, all state on its rising edge
//   rst_i : asynchronous active-low reset
//   bus   : int_rdy_ctrl_if.slave (requests in, registered results out)
// Parameters:
//   SYNC_STAGES : synchroniser depth per asynchronous input (2..4)
//   IRQ_FILT    : consecutive low samples required to assert IRQ (1..7)
module int_rdy_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IRQ_FILT    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  int_rdy_ctrl_if.slave bus
);

  localparam logic [2:0] FILT_MAX = 3'(IRQ_FILT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } nmi_state_t;

  // Synchronisers
  logic [SYNC_STAGES-1:0] irq_sync;
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic [SYNC_STAGES-1:0] vld_sync;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_sync <= '1;
      nmi_sync <= '1;
      rdy_sync <= '0;
      vld_sync <= '0;
    end else begin
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], bus.ext_irq_n_i};
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], bus.ext_nmi_n_i};
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], bus.ext_rdy_i};
      vld_sync <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic irq_s;
  logic nmi_s;
  logic rdy_s;
  logic nmi_vld;

  assign irq_s   = irq_sync[SYNC_STAGES-1];
  assign nmi_s   = nmi_sync[SYNC_STAGES-1];
  assign rdy_s   = rdy_sync[SYNC_STAGES-1];
  assign nmi_vld = vld_sync[SYNC_STAGES-1];

  // IRQ filter
  logic [2:0] irq_cnt;
  logic [2:0] irq_cnt_n;
  logic       irq_q;

  always_comb begin
    irq_cnt_n = irq_cnt;
    if (irq_s) begin
      irq_cnt_n = '0;
    end else if (irq_cnt != FILT_MAX) begin
      irq_cnt_n = irq_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_cnt <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_cnt <= irq_cnt_n;
      irq_q   <= (irq_cnt_n == FILT_MAX);
    end
  end

  // NMI edge detect.
  // The previous-value register only takes synchroniser samples that came
  // from the pin after reset release (nmi_vld); otherwise the reset-loaded
  // 1s flushing out of the chain would fake a falling edge when the pin is
  // still held low, re-raising an NMI that reset was meant to discard.
  logic nmi_prev;
  logic nmi_edge;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      nmi_prev <= 1'b0;
    end else begin
      nmi_prev <= nmi_vld & nmi_s;
    end
  end

  assign nmi_edge = nmi_vld & nmi_prev & ~nmi_s;

  // NMI FSM
  nmi_state_t state;
  nmi_state_t state_n;
  logic       rearm;
  logic       rearm_n;
  logic [7:0] nmi_cnt;
  logic [7:0] nmi_cnt_n;
  logic       nmi_q;

  always_comb begin
    state_n   = state;
    rearm_n   = rearm;
    nmi_cnt_n = nmi_cnt;
    case (state)
      IDLE: begin
        if (nmi_edge) begin
          state_n = PEND;
        end
      end
      PEND: begin
        if (nmi_edge) begin
          rearm_n = 1'b1;
        end
        if (bus.nmi_ack_i) begin
          state_n = SERV;
          if (nmi_cnt != 8'hFF) begin
            nmi_cnt_n = nmi_cnt + 8'd1;
          end
        end
      end
      SERV: begin
        // SERV lasts one cycle, so an edge arriving now is folded straight
        // into the re-arm decision instead of being parked in the flag.
        if (rearm || nmi_edge) begin
          state_n = PEND;
          rearm_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        rearm_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      rearm   <= 1'b0;
      nmi_cnt <= '0;
      nmi_q   <= 1'b0;
    end else begin
      state   <= state_n;
      rearm   <= rearm_n;
      nmi_cnt <= nmi_cnt_n;
      nmi_q   <= (state_n == PEND);
    end
  end

  // Ready / single-step
  logic step_prev;
  logic step_rise;
  logic step_pend;
  logic step_pend_n;
  logic rdy_q;
  logic rdy_n;

  assign step_rise = bus.step_i & ~step_prev;

  always_comb begin
    rdy_n       = 1'b0;
    step_pend_n = step_pend;
    if (!bus.step_en_i) begin
      rdy_n       = rdy_s;
      step_pend_n = 1'b0;
    end else if (step_pend) begin
      // Further step edges while pending are dropped here.
      if (rdy_s) begin
        rdy_n       = 1'b1;
        step_pend_n = 1'b0;
      end
    end else if (step_rise) begin
      if (rdy_s) begin
        rdy_n = 1'b1;
      end else begin
        step_pend_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      step_prev <= 1'b0;
      step_pend <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      step_prev <= bus.step_i;
      step_pend <= step_pend_n;
      rdy_q     <= rdy_n;
    end
  end

  assign bus.irq_o     = irq_q;
  assign bus.nmi_o     = nmi_q;
  assign bus.rdy_o     = rdy_q;
  assign bus.nmi_cnt_o = nmi_cnt;

endmodule

// File: tb/tb_int_rdy_ctrl.sv
// Directed bench for int_rdy_ctrl with SYNC_STAGES = 2, IRQ_FILT = 2.
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so a value driven after edge 0 is first captured at edge 1.
module tb_int_rdy_ctrl;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int_rdy_ctrl_if bus();

  int_rdy_ctrl #(.SYNC_STAGES(2), .IRQ_FILT(2)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick(2);
    rst_i = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq_o); end
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL reset_nmi: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", bus.rdy_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h expected 00", bus.nmi_cnt_o); end
    rst_i = 1'b1;
    tick(2);
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL rdy_latency_early: got %b expected 0", bus.rdy_o); end
    tick(1);
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL rdy_latency: got %b expected 1", bus.rdy_o); end
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL post_reset_nmi: got %b expected 0", bus.nmi_o); end
  endtask

  task automatic test_irq_filter();
    bus.ext_irq_n_i = 1'b0;
    tick(3);
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", bus.irq_o); end
    tick(1);
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", bus.irq_o); end
    tick(3);
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL irq_held: got %b expected 1", bus.irq_o); end
    bus.ext_irq_n_i = 1'b1;
    tick(2);
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL irq_release_early: got %b expected 1", bus.irq_o); end
    tick(1);
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL irq_release: got %b expected 0", bus.irq_o); end
    bus.ext_irq_n_i = 1'b0;
    tick(1);
    bus.ext_irq_n_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL irq_glitch cycle %0d: got %b expected 0", i, bus.irq_o); end
    end
  endtask

  task automatic test_nmi_basic();
    bus.ext_nmi_n_i = 1'b0;
    tick(2);
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL nmi_early: got %b expected 0", bus.nmi_o); end
    tick(1);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL nmi_pend: got %b expected 1", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h00) begin errors++; $display("FAIL nmi_cnt_before_ack: got %h expected 00", bus.nmi_cnt_o); end
    tick(2);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL nmi_hold_before_ack: got %b expected 1", bus.nmi_o); end
    bus.nmi_ack_i = 1'b1;
    tick(1);
    bus.nmi_ack_i = 1'b0;
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL nmi_after_ack: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h01) begin errors++; $display("FAIL nmi_cnt_after_ack: got %h expected 01", bus.nmi_cnt_o); end
    tick(1);
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL nmi_idle_level_low: got %b expected 0", bus.nmi_o); end
    bus.nmi_ack_i = 1'b1;
    tick(1);
    bus.nmi_ack_i = 1'b0;
    tick(2);
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL ack_in_idle_nmi: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h01) begin errors++; $display("FAIL ack_in_idle_cnt: got %h expected 01", bus.nmi_cnt_o); end
    bus.ext_nmi_n_i = 1'b1;
    tick(3);
  endtask

  task automatic test_nmi_rearm();
    do_reset();
    bus.ext_nmi_n_i = 1'b0;
    tick(3);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL rearm_enter_pend: got %b expected 1", bus.nmi_o); end
    for (int i = 0; i < 3; i++) begin
      bus.ext_nmi_n_i = 1'b1;
      tick(3);
      bus.ext_nmi_n_i = 1'b0;
      tick(3);
      checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL rearm_pend_edge %0d: got %b expected 1", i, bus.nmi_o); end
    end
    bus.nmi_ack_i = 1'b1;
    tick(1);
    bus.nmi_ack_i = 1'b0;
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL rearm_serv1: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h01) begin errors++; $display("FAIL rearm_cnt1: got %h expected 01", bus.nmi_cnt_o); end
    tick(1);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL rearm_pend2: got %b expected 1", bus.nmi_o); end
    tick(2);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL rearm_pend2_hold: got %b expected 1", bus.nmi_o); end
    bus.nmi_ack_i = 1'b1;
    tick(1);
    bus.nmi_ack_i = 1'b0;
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL rearm_serv2: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h02) begin errors++; $display("FAIL rearm_cnt2: got %h expected 02", bus.nmi_cnt_o); end
    tick(1);
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL rearm_idle: got %b expected 0", bus.nmi_o); end
    tick(4);
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL rearm_collapsed: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h02) begin errors++; $display("FAIL rearm_cnt_final: got %h expected 02", bus.nmi_cnt_o); end
    // Edge coinciding with the ack in PEND
    bus.ext_nmi_n_i = 1'b1;
    tick(3);
    bus.ext_nmi_n_i = 1'b0;
    tick(3);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL coinc_pend: got %b expected 1", bus.nmi_o); end
    bus.ext_nmi_n_i = 1'b1;
    tick(3);
    bus.ext_nmi_n_i = 1'b0;
    tick(2);
    bus.nmi_ack_i = 1'b1;
    tick(1);
    bus.nmi_ack_i = 1'b0;
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL coinc_serv: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h03) begin errors++; $display("FAIL coinc_cnt: got %h expected 03", bus.nmi_cnt_o); end
    tick(1);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL coinc_rearmed: got %b expected 1", bus.nmi_o); end
    bus.nmi_ack_i = 1'b1;
    tick(1);
    bus.nmi_ack_i = 1'b0;
    tick(1);
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL coinc_done: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h04) begin errors++; $display("FAIL coinc_cnt_final: got %h expected 04", bus.nmi_cnt_o); end
    bus.ext_nmi_n_i = 1'b1;
    tick(3);
  endtask

  task automatic test_nmi_saturate();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      bus.ext_nmi_n_i = 1'b0;
      tick(3);
      bus.nmi_ack_i = 1'b1;
      tick(1);
      bus.nmi_ack_i = 1'b0;
      bus.ext_nmi_n_i = 1'b1;
      tick(3);
      if (i == 254) begin
        checks++; if (bus.nmi_cnt_o !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %h expected ff", bus.nmi_cnt_o); end
      end
    end
    checks++; if (bus.nmi_cnt_o !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h expected ff", bus.nmi_cnt_o); end
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL sat_nmi_idle: got %b expected 0", bus.nmi_o); end
  endtask

  task automatic test_reset_mid_pend();
    bus.ext_irq_n_i = 1'b0;
    bus.ext_nmi_n_i = 1'b0;
    tick(4);
    checks++; if (bus.nmi_o !== 1'b1) begin errors++; $display("FAIL midrst_pend: got %b expected 1", bus.nmi_o); end
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL midrst_irq_pre: got %b expected 1", bus.irq_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL midrst_async_nmi: got %b expected 0", bus.nmi_o); end
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL midrst_async_irq: got %b expected 0", bus.irq_o); end
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL midrst_async_rdy: got %b expected 0", bus.rdy_o); end
    checks++; if (bus.nmi_cnt_o !== 8'h00) begin errors++; $display("FAIL midrst_async_cnt: got %h expected 00", bus.nmi_cnt_o); end
    tick(2);
    rst_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++; if (bus.nmi_o !== 1'b0) begin errors++; $display("FAIL midrst_no_nmi cycle %0d: got %b expected 0", i, bus.nmi_o); end
    end
    bus.ext_irq_n_i = 1'b1;
    bus.ext_nmi_n_i = 1'b1;
    tick(4);
  endtask

  task automatic test_step();
    int highs;
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL step_follow: got %b expected 1", bus.rdy_o); end
    bus.step_en_i = 1'b1;
    tick(1);
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL step_en_blocks: got %b expected 0", bus.rdy_o); end
    tick(2);
    bus.step_i = 1'b1;
    tick(1);
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL step1_pulse: got %b expected 1", bus.rdy_o); end
    bus.step_i = 1'b0;
    highs = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (bus.rdy_o === 1'b1) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL step1_single: got %0d extra cycles expected 0", highs); end
    bus.step_i = 1'b1;
    tick(1);
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL step2_pulse: got %b expected 1", bus.rdy_o); end
    tick(2);
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL step2_level_held: got %b expected 0", bus.rdy_o); end
    bus.step_i = 1'b0;
    // Step while ready is low: held pending, second edge dropped
    bus.ext_rdy_i = 1'b0;
    tick(3);
    bus.step_i = 1'b1;
    tick(1);
    bus.step_i = 1'b0;
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL step_pend_wait: got %b expected 0", bus.rdy_o); end
    tick(1);
    bus.step_i = 1'b1;
    tick(1);
    bus.step_i = 1'b0;
    tick(2);
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL step_pend_hold: got %b expected 0", bus.rdy_o); end
    bus.ext_rdy_i = 1'b1;
    tick(2);
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL step_pend_early: got %b expected 0", bus.rdy_o); end
    tick(1);
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL step_pend_issue: got %b expected 1", bus.rdy_o); end
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.rdy_o === 1'b1) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL step_pend_dropped: got %0d extra cycles expected 0", highs); end
    // Leaving step mode clears a pending step
    bus.ext_rdy_i = 1'b0;
    tick(3);
    bus.step_i = 1'b1;
    tick(1);
    bus.step_i = 1'b0;
    bus.step_en_i = 1'b0;
    tick(1);
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL step_clear_follow: got %b expected 0", bus.rdy_o); end
    bus.step_en_i = 1'b1;
    bus.ext_rdy_i = 1'b1;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.rdy_o === 1'b1) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL step_clear_pending: got %0d cycles expected 0", highs); end
    bus.step_en_i = 1'b0;
    tick(1);
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL step_exit_follow: got %b expected 1", bus.rdy_o); end
  endtask

  initial begin
    bus.ext_irq_n_i = 1'b1;
    bus.ext_nmi_n_i = 1'b1;
    bus.ext_rdy_i   = 1'b1;
    bus.nmi_ack_i   = 1'b0;
    bus.step_en_i   = 1'b0;
    bus.step_i      = 1'b0;
    test_reset();
    test_irq_filter();
    test_nmi_basic();
    test_nmi_rearm();
    test_nmi_saturate();
    test_reset_mid_pend();
    test_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
